preg_release_unit: RTL and testbench
====================================

Name: preg_release_unit

Overview:
- Commit-side producer for the physical-register freelist. It receives up to two retiring instructions per cycle and collects their old physical destination registers.
- Buffers those registers in a small staging queue, then pushes them back into the freelist through its dual write port.
- Honours freelist occupancy and never asserts the second write lane alone.
- Sits between the ROB retire stage and the freelist; the rename allocator is the reader at the freelist's other end.

Parameters:
- FL_SIZE, 31, freelist capacity (physical regs 1..31; p0 is never allocated or freed).
- PREG_WIDTH, 5, physical register index width.
- FL_NUM_WIDTH, 5, width of the freelist occupancy count.
- BUF_DEPTH, 4, staging queue entries (power of two, >=2).
- BUF_PTR_WIDTH, 2, log2(BUF_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- retire_first_vld_i  in  1  retire lane 0 valid.
- retire_first_has_rd_i  in  1  lane 0 instruction wrote a destination.
- retire_first_old_prd_i  in  PREG_WIDTH  lane 0 previous mapping of its arch rd.
- retire_second_vld_i  in  1  retire lane 1 valid (lane 1 is younger).
- retire_second_has_rd_i  in  1  lane 1 instruction wrote a destination.
- retire_second_old_prd_i  in  PREG_WIDTH  lane 1 previous mapping.
- retire_rdy_o  out  1  unit can accept two releases this cycle.
- fl_num_i  in  FL_NUM_WIDTH  current freelist occupancy.
- fl_wr_first_en_o  out  1  freelist write lane 0 enable.
- fl_wr_second_en_o  out  1  freelist write lane 1 enable.
- fl_wdata_first_o  out  PREG_WIDTH  lane 0 register index.
- fl_wdata_second_o  out  PREG_WIDTH  lane 1 register index.
- drained_o  out  1  staging queue empty and no write in flight.

Behaviour:
- Clock/reset: one clock. Reset is asynchronous, active-high. Reset clears the staging queue, head, tail and count to 0.
- Reset values: retire_rdy_o=1, fl_wr_*_en_o=0, fl_wdata_*_o=0, drained_o=1.
- Accept:
  - Lane k is releasable when vld & has_rd & (old_prd != 0). p0 is silently dropped.
  - retire_rdy_o = (BUF_DEPTH - count >= 2), combinational from registered count.
  - If retire_rdy_o=0, retire inputs are ignored; ROB must hold them.
  - Enqueue order is lane 0 then lane 1.
  - If only lane 1 is releasable, it takes the tail slot (compaction; no hole).
- Drain:
  - space = FL_SIZE - fl_num_i.
  - n = min(count, 2, space).
  - n>=1: fl_wr_first_en_o=1 with the head entry.
  - n==2: fl_wr_second_en_o=1 with head+1.
  - fl_wr_second_en_o=1 with fl_wr_first_en_o=0 is illegal and must never occur.
  - Outputs are combinational from registered queue state; freelist captures on the same edge that the head advances by n.
- Latency: a release accepted at edge N is written to the freelist at edge N+1 at the earliest.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq - n, with no stall. Pointers wrap modulo BUF_DEPTH.
- Freelist full (space=0): no writes; entries are held. Once count exceeds BUF_DEPTH-2, retire_rdy_o drops.
- Space==1 with count>=2: only the first lane is written.
- drained_o = (count==0).
- Reset mid-operation clears queued entries; they are not replayed because the freelist reinitialises on the same reset.

Optional Feature:
- Macro PREG_RELEASE_STATS_EN.
- Defined:
  - Adds output rel_cnt_o[31:0]: count of registers written to the freelist (+n per cycle), wraps at 2^32, reset 0.
  - Adds output drop_p0_cnt_o[15:0]: count of lanes with vld & has_rd & old_prd==0, saturating, reset 0.
- Undefined: neither port nor its counter exists; all other behaviour is identical.

Decomposition:
- Shared package preg_pkg holds:
  - PREG_WIDTH and FL_SIZE constants.
  - preg_idx_t typedef.
  - PREG_ZERO constant.
  - release_lane_t struct {vld, has_rd, old_prd}.
- One sub-module, preg_release_stq: a 2-in/2-out circular staging queue with compacting enqueue and variable 0..2 dequeue. The top level holds the releasable filter, space computation and the optional stats counters.

Test Plan:
- Reset, then both lanes releasing p7,p9 with fl_num_i=20 -> next cycle fl_wr_first_en_o=1/p7, fl_wr_second_en_o=1/p9; then drained_o=1.
- Lane 0 old_prd=0, lane 1 releasing p4 -> only fl_wr_first_en_o=1 with p4; second enable stays 0.
- fl_num_i=31 held; 2 retire pairs (p1..p4) -> no writes, count=4, retire_rdy_o=0. Set fl_num_i=30 -> one cycle writes p1 on first lane only.
- Continuous dual retire every cycle with fl_num_i=0 for 10 cycles -> two writes per cycle, retire_rdy_o stays 1, FIFO order preserved across pointer wrap.
- Assert rst asynchronously with 3 entries queued -> outputs drop to their reset values immediately (without waiting for a clock edge); no writes after reset release.
- With PREG_RELEASE_STATS_EN: 5 releases plus 2 p0 lanes -> rel_cnt_o=5, drop_p0_cnt_o=2.

Source files
------------

// File: rtl/preg_pkg.sv
// Shared physical-register types and constants for the release path.
package preg_pkg;

    localparam int unsigned PREG_WIDTH = 5;
    localparam int unsigned FL_SIZE    = 31;

    typedef logic [PREG_WIDTH-1:0] preg_idx_t;

    localparam preg_idx_t PREG_ZERO = '0;

    typedef struct packed {
        logic      vld;
        logic      has_rd;
        preg_idx_t old_prd;
    } release_lane_t;

    // p0 is hardwired and never returns to the freelist.
    function automatic logic lane_releasable(release_lane_t lane);
        return lane.vld & lane.has_rd & (lane.old_prd != PREG_ZERO);
    endfunction

endpackage

// File: rtl/preg_release_stq.sv
// Two-in/two-out circular staging queue: compacting enqueue, 0..2 entry dequeue per cycle.
module preg_release_stq
    import preg_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_first_vld,
    input  preg_idx_t            enq_first_data,
    input  logic                 enq_second_vld,
    input  preg_idx_t            enq_second_data,
    input  logic [1:0]           deq_num,
    output preg_idx_t            head_first,
    output preg_idx_t            head_second,
    output logic [PTR_WIDTH:0]   count
);

    localparam int unsigned CNT_W = PTR_WIDTH + 1;

    preg_idx_t              mem_q [DEPTH];
    preg_idx_t              mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_WIDTH-1:0]   second_slot, head_plus1;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             enq_num;

    always_comb begin
        mem_d       = mem_q;
        enq_num     = {1'b0, enq_first_vld} + {1'b0, enq_second_vld};
        // A lone second lane lands on the tail so the queue never holds a hole.
        second_slot = enq_first_vld ? tail_q + PTR_WIDTH'(1) : tail_q;
        if (enq_first_vld) begin
            mem_d[tail_q] = enq_first_data;
        end
        if (enq_second_vld) begin
            mem_d[second_slot] = enq_second_data;
        end
        tail_d  = tail_q + PTR_WIDTH'(enq_num);
        head_d  = head_q + PTR_WIDTH'(deq_num);
        count_d = count_q + CNT_W'(enq_num) - CNT_W'(deq_num);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_plus1  = head_q + PTR_WIDTH'(1);
    assign head_first  = mem_q[head_q];
    assign head_second = mem_q[head_plus1];
    assign count       = count_q;

endmodule

// File: rtl/preg_release_unit.sv
// Collects retiring old physical destinations and returns them to the freelist.
// Optional statistics counters when PREG_RELEASE_STATS_EN is defined.
module preg_release_unit
    import preg_pkg::*;
#(
    parameter int unsigned FL_NUM_WIDTH  = 5,
    parameter int unsigned BUF_DEPTH     = 4,
    parameter int unsigned BUF_PTR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    retire_first_vld_i,
    input  logic                    retire_first_has_rd_i,
    input  logic [PREG_WIDTH-1:0]   retire_first_old_prd_i,
    input  logic                    retire_second_vld_i,
    input  logic                    retire_second_has_rd_i,
    input  logic [PREG_WIDTH-1:0]   retire_second_old_prd_i,
    output logic                    retire_rdy_o,
    input  logic [FL_NUM_WIDTH-1:0] fl_num_i,
    output logic                    fl_wr_first_en_o,
    output logic                    fl_wr_second_en_o,
    output logic [PREG_WIDTH-1:0]   fl_wdata_first_o,
    output logic [PREG_WIDTH-1:0]   fl_wdata_second_o,
    output logic                    drained_o
`ifdef PREG_RELEASE_STATS_EN
    ,
    output logic [31:0]             rel_cnt_o,
    output logic [15:0]             drop_p0_cnt_o
`endif
);

    localparam int unsigned CNT_W = BUF_PTR_WIDTH + 1;

    release_lane_t          lane_first, lane_second;
    logic                   rel_first, rel_second;
    logic [CNT_W-1:0]       count;
    logic [1:0]             deq_num;
    logic [31:0]            space_w, count_w, n_w;
    preg_idx_t              head_first, head_second;

    assign lane_first  = '{vld: retire_first_vld_i, has_rd: retire_first_has_rd_i,
                           old_prd: retire_first_old_prd_i};
    assign lane_second = '{vld: retire_second_vld_i, has_rd: retire_second_has_rd_i,
                           old_prd: retire_second_old_prd_i};

    assign retire_rdy_o = (32'(count) + 32'd2 <= 32'(BUF_DEPTH));
    assign rel_first    = lane_releasable(lane_first) & retire_rdy_o;
    assign rel_second   = lane_releasable(lane_second) & retire_rdy_o;

    // n = min(count, 2, space); occupancy above FL_SIZE is treated as no space.
    always_comb begin
        count_w = 32'(count);
        space_w = (32'(fl_num_i) >= 32'(FL_SIZE)) ? 32'd0 : 32'(FL_SIZE) - 32'(fl_num_i);
        n_w     = 32'd2;
        if (count_w < n_w) begin
            n_w = count_w;
        end
        if (space_w < n_w) begin
            n_w = space_w;
        end
        deq_num = 2'(n_w);
    end

    preg_release_stq #(
        .DEPTH     (BUF_DEPTH),
        .PTR_WIDTH (BUF_PTR_WIDTH)
    ) u_stq (
        .clk             (clk),
        .rst             (rst),
        .enq_first_vld   (rel_first),
        .enq_first_data  (lane_first.old_prd),
        .enq_second_vld  (rel_second),
        .enq_second_data (lane_second.old_prd),
        .deq_num         (deq_num),
        .head_first      (head_first),
        .head_second     (head_second),
        .count           (count)
    );

    assign fl_wr_first_en_o  = (deq_num != 2'd0);
    assign fl_wr_second_en_o = (deq_num == 2'd2);
    assign fl_wdata_first_o  = fl_wr_first_en_o  ? head_first  : PREG_ZERO;
    assign fl_wdata_second_o = fl_wr_second_en_o ? head_second : PREG_ZERO;
    assign drained_o         = (count == '0);

`ifdef PREG_RELEASE_STATS_EN
    logic [31:0] rel_cnt_q;
    logic [15:0] drop_p0_cnt_q;
    logic [16:0] drop_sum;
    logic [1:0]  drop_num;

    // Only accepted lanes count; a held retire is re-presented by the ROB.
    always_comb begin
        drop_num = {1'b0, lane_first.vld & lane_first.has_rd & (lane_first.old_prd == PREG_ZERO)}
                 + {1'b0, lane_second.vld & lane_second.has_rd
                          & (lane_second.old_prd == PREG_ZERO)};
        if (!retire_rdy_o) begin
            drop_num = 2'd0;
        end
        drop_sum = {1'b0, drop_p0_cnt_q} + 17'(drop_num);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_cnt_q     <= '0;
            drop_p0_cnt_q <= '0;
        end else begin
            rel_cnt_q     <= rel_cnt_q + 32'(deq_num);
            drop_p0_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign rel_cnt_o     = rel_cnt_q;
    assign drop_p0_cnt_o = drop_p0_cnt_q;
`endif

endmodule

// File: tb/tb_preg_release_unit.sv
// Directed, table-driven bench for preg_release_unit.
module tb_preg_release_unit;

    logic       clk;
    logic       rst;
    logic       l0_vld, l0_rd, l1_vld, l1_rd;
    logic [4:0] l0_prd, l1_prd;
    logic       rdy;
    logic [4:0] fl_num;
    logic       en1, en2;
    logic [4:0] wd1, wd2;
    logic       drained;
`ifdef PREG_RELEASE_STATS_EN
    logic [31:0] rel_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    preg_release_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .retire_first_vld_i      (l0_vld),
        .retire_first_has_rd_i   (l0_rd),
        .retire_first_old_prd_i  (l0_prd),
        .retire_second_vld_i     (l1_vld),
        .retire_second_has_rd_i  (l1_rd),
        .retire_second_old_prd_i (l1_prd),
        .retire_rdy_o            (rdy),
        .fl_num_i                (fl_num),
        .fl_wr_first_en_o        (en1),
        .fl_wr_second_en_o       (en2),
        .fl_wdata_first_o        (wd1),
        .fl_wdata_second_o       (wd2),
        .drained_o               (drained)
`ifdef PREG_RELEASE_STATS_EN
        ,
        .rel_cnt_o               (rel_cnt),
        .drop_p0_cnt_o           (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0, h0;
        logic [4:0] p0;
        logic       v1, h1;
        logic [4:0] p1;
        logic [4:0] fl;
        logic       rdy, e1, e2;
        logic [4:0] w1, w2;
        logic       drn;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic v0, logic h0, logic [4:0] p0, logic v1, logic h1,
                                logic [4:0] p1, logic [4:0] fl, logic r, logic e1, logic e2,
                                logic [4:0] w1, logic [4:0] w2, logic drn);
        vec_t v;
        v.v0 = v0; v.h0 = h0; v.p0 = p0; v.v1 = v1; v.h1 = h1; v.p1 = p1; v.fl = fl;
        v.rdy = r; v.e1 = e1; v.e2 = e2; v.w1 = w1; v.w2 = w2; v.drn = drn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic e1, input logic e2,
                           input logic [4:0] w1, input logic [4:0] w2, input logic drn);
        chk({tag, ".rdy"}, 32'(rdy), 32'(r));
        chk({tag, ".en1"}, 32'(en1), 32'(e1));
        chk({tag, ".en2"}, 32'(en2), 32'(e2));
        chk({tag, ".wd1"}, 32'(wd1), 32'(w1));
        chk({tag, ".wd2"}, 32'(wd2), 32'(w2));
        chk({tag, ".drained"}, 32'(drained), 32'(drn));
        n_cmp++;
        if (en2 && !en1) begin
            n_err++;
            $display("FAIL %s.lane2_alone: en1=%0b en2=%0b", tag, en1, en2);
        end
    endtask

    task automatic drive(input logic v0, input logic h0, input logic [4:0] p0,
                         input logic v1, input logic h1, input logic [4:0] p1);
        l0_vld = v0; l0_rd = h0; l0_prd = p0;
        l1_vld = v1; l1_rd = h1; l1_prd = p1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [4:0] sb [$];
    logic [4:0] a, b;

    initial begin
        rst = 1'b1;
        fl_num = 5'd20;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 chk_out("reset", 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        // Each row: inputs for one cycle, outputs expected during that cycle.
        vecs.push_back(mk(1,1,7, 1,1,9, 20, 1,0,0, 0,0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 20, 1,1,1, 7,9, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 20, 1,0,0, 0,0, 1));
        vecs.push_back(mk(1,1,0, 1,1,4, 20, 1,0,0, 0,0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 20, 1,1,0, 4,0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 20, 1,0,0, 0,0, 1));
        vecs.push_back(mk(1,1,1, 1,1,2, 31, 1,0,0, 0,0, 1));
        vecs.push_back(mk(1,1,3, 1,1,4, 31, 1,0,0, 0,0, 0));
        vecs.push_back(mk(1,1,5, 1,1,6, 31, 0,0,0, 0,0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 30, 0,1,0, 1,0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 30, 0,1,0, 2,0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0,  0, 1,1,1, 3,4, 0));
        vecs.push_back(mk(1,0,10, 0,1,11, 0, 1,0,0, 0,0, 1));
        vecs.push_back(mk(1,1,12, 1,0,13, 0, 1,0,0, 0,0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0,  0, 1,1,0, 12,0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0,  0, 1,0,0, 0,0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].h0, vecs[i].p0, vecs[i].v1, vecs[i].h1, vecs[i].p1);
            fl_num = vecs[i].fl;
            #1 chk_out($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].e1, vecs[i].e2,
                       vecs[i].w1, vecs[i].w2, vecs[i].drn);
        end

        // Continuous dual retire with an empty freelist; exercises pointer wrap.
        fl_num = 5'd0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            a = 5'(1 + 2 * i);
            b = 5'(2 + 2 * i);
            if (i < 10) drive(1, 1, a, 1, 1, b);
            else        drive(0, 0, 0, 0, 0, 0);
            #1;
            if (sb.size() >= 2) begin
                chk_out($sformatf("stream%0d", i), 1, 1, 1, sb[0], sb[1], 0);
                void'(sb.pop_front());
                void'(sb.pop_front());
            end else begin
                chk_out($sformatf("stream%0d", i), 1, 0, 0, 0, 0, 1);
            end
            if (i < 10) begin
                sb.push_back(a);
                sb.push_back(b);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_out("stream_end", 1, 0, 0, 0, 0, 1);

        // Asynchronous reset with three entries queued.
        fl_num = 5'd31;
        @(negedge clk);
        drive(1, 1, 5'd21, 1, 1, 5'd22);
        @(negedge clk);
        drive(1, 1, 5'd23, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        fl_num = 5'd20;
        #1 chk_out("pre_arst", 0, 1, 1, 21, 22, 0);
        #1 rst = 1'b1;
        #1 chk_out("arst", 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk_out($sformatf("post_arst%0d", i), 1, 0, 0, 0, 0, 1);
        end

`ifdef PREG_RELEASE_STATS_EN
        do_reset();
        fl_num = 5'd0;
        drive(1, 1, 5'd1, 1, 1, 5'd2);
        @(negedge clk);
        drive(1, 1, 5'd0, 1, 1, 5'd3);
        @(negedge clk);
        drive(1, 1, 5'd4, 1, 1, 5'd0);
        @(negedge clk);
        drive(1, 1, 5'd5, 0, 0, 5'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        chk("stats.rel_cnt", rel_cnt, 32'd5);
        chk("stats.drop_p0", 32'(drop_cnt), 32'd2);
        chk("stats.drained", 32'(drained), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
